// File: rtl/uart_bus_master_pkg.sv
// rtl/uart_bus_master_pkg.sv - shared command/response bytes and FSM encoding for uart_bus_master
package uart_bus_master_pkg;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    typedef enum logic [3:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WDATA,
        S_BUS_WR,
        S_BUS_RD,
        S_RD_WAIT,
        S_TX_LOAD,
        S_TX_WAIT
    } state_t;

endpackage

// File: rtl/uart.sv
// rtl/uart.sv - 8N1 UART core with one-byte receive holding register and byte transmitter
module uart #(
    parameter int freq_hz = 50000000,
    parameter int baud    = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       rx_error,
    input  logic       rx_ack,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_busy
);
    localparam int          CPB    = freq_hz / baud;
    localparam logic [15:0] BIT_T  = 16'(CPB - 1);
    localparam logic [15:0] HALF_T = 16'(CPB / 2 - 1);

    logic        r_rx_s1, r_rx_s2, r_rx_prev, r_rx_busy, r_rx_avail, r_rx_err;
    logic [15:0] r_rx_cnt;
    logic [3:0]  r_rx_bit;
    logic [7:0]  r_rx_sh, r_rx_data;

    logic        r_tx_busy;
    logic [15:0] r_tx_cnt;
    logic [3:0]  r_tx_bit;
    logic [9:0]  r_tx_sh;

    // Start is a falling edge, so a low stop bit after a framing error cannot retrigger
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_busy  <= 1'b0;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_sh    <= '0;
            r_rx_data  <= '0;
            r_rx_avail <= 1'b0;
            r_rx_err   <= 1'b0;
        end else begin
            r_rx_s1   <= rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            if (rx_ack)
                r_rx_avail <= 1'b0;
            if (!r_rx_busy) begin
                if (r_rx_prev && !r_rx_s2) begin
                    r_rx_busy <= 1'b1;
                    r_rx_cnt  <= HALF_T;
                    r_rx_bit  <= '0;
                end
            end else if (r_rx_cnt != 16'd0) begin
                r_rx_cnt <= r_rx_cnt - 16'd1;
            end else begin
                r_rx_cnt <= BIT_T;
                r_rx_bit <= r_rx_bit + 4'd1;
                if (r_rx_bit == 4'd0) begin
                    if (r_rx_s2)
                        r_rx_busy <= 1'b0;
                end else if (r_rx_bit == 4'd9) begin
                    r_rx_data  <= r_rx_sh;
                    r_rx_avail <= 1'b1;
                    r_rx_err   <= !r_rx_s2;
                    r_rx_busy  <= 1'b0;
                end else begin
                    r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_busy <= 1'b0;
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
            r_tx_sh   <= '1;
        end else if (!r_tx_busy) begin
            if (tx_wr) begin
                r_tx_sh   <= {1'b1, tx_data, 1'b0};
                r_tx_busy <= 1'b1;
                r_tx_cnt  <= BIT_T;
                r_tx_bit  <= '0;
            end
        end else if (r_tx_cnt != 16'd0) begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
        end else begin
            r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
            r_tx_cnt <= BIT_T;
            r_tx_bit <= r_tx_bit + 4'd1;
            if (r_tx_bit == 4'd9)
                r_tx_busy <= 1'b0;
        end
    end

    assign tx       = r_tx_sh[0];
    assign tx_busy  = r_tx_busy;
    assign rx_data  = r_rx_data;
    assign rx_avail = r_rx_avail;
    assign rx_error = r_rx_err;

endmodule

// File: rtl/uart_bus_master.sv
// rtl/uart_bus_master.sv - host UART frames to single 32-bit bus reads/writes with byte responses
module uart_bus_master
    import uart_bus_master_pkg::*;
#(
    parameter int clk_freq       = 50000000,
    parameter int baud           = 115200,
    parameter int timeout_cycles = 500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        uart_tx,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_wr,
    output logic        bus_rd,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic        active
);
    localparam int TW = $clog2(timeout_cycles + 1);

    logic [7:0]  w_rx_data, w_tx_data;
    logic        w_rx_avail, w_rx_error, w_rx_ack, w_tx_wr, w_tx_busy, w_tmo_hit;
    state_t      r_state, w_next;
    logic [1:0]  r_cnt;
    logic        r_is_wr, r_bus_wr, r_bus_rd;
    logic [7:0]  r_cmd;
    logic [31:0] r_bus_addr, r_bus_wdata, r_tx_buf;
    logic [2:0]  r_tx_left;
    logic [TW-1:0] r_tmo;

    uart #(.freq_hz(clk_freq), .baud(baud)) u_uart (
        .clk      (clk),
        .rst      (rst),
        .rx       (uart_rx),
        .tx       (uart_tx),
        .rx_data  (w_rx_data),
        .rx_avail (w_rx_avail),
        .rx_error (w_rx_error),
        .rx_ack   (w_rx_ack),
        .tx_data  (w_tx_data),
        .tx_wr    (w_tx_wr),
        .tx_busy  (w_tx_busy)
    );

    assign w_tmo_hit = (r_tmo == TW'(timeout_cycles));

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_rx_ack  = 1'b0;
        w_tx_wr   = 1'b0;
        w_tx_data = r_tx_buf[7:0];
        case (r_state)
            S_IDLE: if (w_rx_avail) begin
                w_rx_ack = 1'b1;
                if (!w_rx_error) w_next = S_CMD;
            end
            S_CMD: w_next = (r_cmd == CMD_WRITE || r_cmd == CMD_READ) ? S_ADDR : S_TX_LOAD;
            S_ADDR: if (w_rx_avail) begin
                w_rx_ack = 1'b1;
                if (w_rx_error)          w_next = S_IDLE;
                else if (r_cnt == 2'd3)  w_next = r_is_wr ? S_WDATA : S_BUS_RD;
            end else if (w_tmo_hit) begin
                w_next = S_IDLE;
            end
            S_WDATA: if (w_rx_avail) begin
                w_rx_ack = 1'b1;
                if (w_rx_error)          w_next = S_IDLE;
                else if (r_cnt == 2'd3)  w_next = S_BUS_WR;
            end else if (w_tmo_hit) begin
                w_next = S_IDLE;
            end
            S_BUS_WR:  w_next = S_TX_LOAD;
            S_BUS_RD:  w_next = S_RD_WAIT;
            S_RD_WAIT: if (!bus_busy) w_next = S_TX_LOAD;
            S_TX_LOAD: if (!w_tx_busy) begin
                w_tx_wr = 1'b1;
                w_next  = S_TX_WAIT;
            end
            // One cycle here keeps tx_busy unsampled until two cycles after tx_wr
            S_TX_WAIT: w_next = (r_tx_left == 3'd0) ? S_IDLE : S_TX_LOAD;
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_cmd       <= '0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_bus_wr    <= 1'b0;
            r_bus_rd    <= 1'b0;
            r_tx_buf    <= '0;
            r_tx_left   <= '0;
            r_tmo       <= '0;
        end else begin
            r_bus_wr <= (w_next == S_BUS_WR);
            r_bus_rd <= (w_next == S_BUS_RD);
            if ((r_state == S_ADDR || r_state == S_WDATA) && !w_rx_ack)
                r_tmo <= w_tmo_hit ? r_tmo : r_tmo + 1'b1;
            else
                r_tmo <= '0;
            case (r_state)
                S_IDLE: if (w_rx_ack) r_cmd <= w_rx_data;
                S_CMD: begin
                    r_cnt     <= '0;
                    r_is_wr   <= (r_cmd == CMD_WRITE);
                    r_tx_buf  <= {24'h0, RSP_ERR};
                    r_tx_left <= 3'd1;
                end
                S_ADDR: if (w_rx_ack && !w_rx_error) begin
                    r_bus_addr[{r_cnt, 3'b000} +: 8] <= w_rx_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                S_WDATA: if (w_rx_ack && !w_rx_error) begin
                    r_bus_wdata[{r_cnt, 3'b000} +: 8] <= w_rx_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                S_BUS_WR: begin
                    r_tx_buf  <= {24'h0, RSP_ACK};
                    r_tx_left <= 3'd1;
                end
                S_RD_WAIT: if (!bus_busy) begin
                    r_tx_buf  <= bus_rdata;
                    r_tx_left <= 3'd4;
                end
                S_TX_LOAD: if (w_tx_wr) begin
                    r_tx_buf  <= r_tx_buf >> 8;
                    r_tx_left <= r_tx_left - 3'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_wr    = r_bus_wr;
    assign bus_rd    = r_bus_rd;
    assign active    = (r_state != S_IDLE);

endmodule

// File: doc/uart_bus_master.md
# uart_bus_master

UART-driven bus initiator for host-side debug and program loading. It receives framed command bytes from a host PC on the serial line and turns them into single 32-bit read or write transactions on the SoC peripheral/memory bus. It returns an acknowledge byte or the read data over the same UART. It sits beside the CPU as a second bus master; an external arbiter grants it the bus.

## Interface

Parameters:
- `clk_freq`, 50000000: system clock in Hz, passed to the UART core.
- `baud`, 115200: serial bit rate.
- `timeout_cycles`, 500000: maximum idle gap between bytes of one frame before the frame is abandoned.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: system clock.
- `rst` in 1: synchronous active-high reset.
- `uart_rx` in 1: serial input from host.
- `uart_tx` out 1: serial output to host; idles high.
- `bus_addr` out 32: transaction byte address.
- `bus_wdata` out 32: write data.
- `bus_wr` out 1: one-cycle write strobe.
- `bus_rd` out 1: one-cycle read strobe.
- `bus_rdata` in 32: read data from the addressed slave.
- `bus_busy` in 1: slave/arbiter stall; read data is not valid while high.
- `active` out 1: high while a frame is in progress, from command byte until response sent.

## Operation

- Host frame format. All multi-byte fields are LSB first.
  - Write: 0x57 ('W'), addr[4], data[4]. Response: 0x4B ('K').
  - Read: 0x52 ('R'), addr[4]. Response: data[4].
  - Any other command byte: response 0x3F ('?'), return to IDLE.
- UART core handshake:
  - Consume each received byte on `rx_avail` by pulsing `rx_ack` for one cycle.
  - Load `tx_data` and pulse `tx_wr` only when `tx_busy`=0.
  - Do not resample `tx_busy` until 2 cycles after the `tx_wr` pulse.
- FSM states: IDLE, CMD, ADDR, WDATA, BUS_WR, BUS_RD, RD_WAIT, TX_LOAD, TX_WAIT.
  - IDLE: on a received byte go to CMD.
  - CMD: classify the byte. 'W' or 'R' go to ADDR with byte count 0. Anything else: queue 0x3F and go to TX_LOAD.
  - ADDR: shift each byte into `bus_addr[8*n +: 8]`. After 4 bytes go to WDATA (for W) or BUS_RD (for R).
  - WDATA: same shifting into `bus_wdata`. After 4 bytes go to BUS_WR.
  - BUS_WR: assert `bus_wr` for 1 cycle, queue 0x4B, go to TX_LOAD.
  - BUS_RD: assert `bus_rd` for 1 cycle, go to RD_WAIT.
  - RD_WAIT: from the cycle after the strobe, capture `bus_rdata` into the response shift register on the first cycle with `bus_busy`=0. Queue 4 bytes and go to TX_LOAD.
  - TX_LOAD / TX_WAIT: send the queued bytes in order. Return to IDLE after the last byte has been handed to the core.
- Timeout: an inter-byte counter resets on every received byte and runs only in ADDR and WDATA. If it reaches `timeout_cycles`, drop the frame silently and return to IDLE with no bus strobe.
- A received byte with `rx_error`=1 is acked and discarded. A frame in progress is dropped, same as a timeout.
- Bytes arriving during BUS_*/RD_WAIT/TX_* stay in the UART core. They are consumed only after return to IDLE.
- Reset values:
  - `bus_addr`=0, `bus_wdata`=0.
  - `bus_wr`=0, `bus_rd`=0.
  - `active`=0, `uart_tx`=1.
  - FSM=IDLE, all counters 0.
  - Reset mid-frame or mid-transmission aborts immediately; no strobe is issued afterward.

## Timing

- `bus_addr` and `bus_wdata` are stable from the strobe cycle until the next frame's first address byte.
- `bus_wr` and `bus_rd` are registered and each is high for exactly one cycle per frame.
- Read-back latency: minimum 1 cycle after `bus_rd`, extended by every `bus_busy`=1 cycle.
- The first response byte's `tx_wr` occurs no later than 2 cycles after the strobe (write) or after data capture (read).
- `active` rises the cycle after the command byte is acked. It falls the cycle the FSM re-enters IDLE.
- Timeout counter width is clog2(`timeout_cycles`+1) and saturates; there is no wrap.

## Structure

- Shared package: command and response byte constants (0x57, 0x52, 0x4B, 0x3F) and the FSM state encoding.
- One sub-module: instantiate the existing `uart` core with `freq_hz`=`clk_freq` and `baud`=`baud`. No new serializer.
- Address/data shift registers and byte counters live in this module.

## Test plan

- Write frame 57 10 00 00 80 EF BE AD DE -> exactly one `bus_wr` with `bus_addr`=0x80000010, `bus_wdata`=0xDEADBEEF; host receives 0x4B.
- Read frame 52 08 00 00 80, `bus_rdata`=0x12345678 with `bus_busy` held high 3 cycles -> one `bus_rd`; capture after busy drops; host receives 78 56 34 12.
- Command byte 0x41 -> host receives 0x3F, no strobe; a following valid 'R' frame completes normally.
- 'W' plus 2 address bytes, then silence > `timeout_cycles` -> no strobe, `active` falls; next full write frame succeeds.
- Framing error injected on the 3rd address byte -> frame dropped, no strobe, no response.
- `rst` pulsed during RD_WAIT -> all outputs at reset values next cycle, `uart_tx` high, no response bytes sent.
